// File: rtl/axi_dma_burst_scheduler.sv
// axi_dma_burst_scheduler
// Splits one block-copy command into AXI INCR bursts. Each burst is capped
// at MAX_BURST beats and never crosses a 4 KB page on either the source or
// the destination side. Every burst is read completely before it is written.
//
// Handshakes: the command is taken on any rising edge where cmd_valid and
// cmd_ready are both high, and cmd_ready is high only in IDLE. start_read,
// start_write and xfer_done are single-cycle pulses. done_read is honoured
// only in RD_WAIT and done_write only in WR_WAIT; pulses at any other time
// are dropped.
module axi_dma_burst_scheduler #(
    parameter int ADDR_WIDTH      = 32,
    parameter int BURST_LEN_WIDTH = 8,
    parameter int MAX_BURST       = 16,
    parameter int COUNT_WIDTH     = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [ADDR_WIDTH-1:0]      cmd_src_addr,
    input  logic [ADDR_WIDTH-1:0]      cmd_dst_addr,
    input  logic [COUNT_WIDTH-1:0]     cmd_words,
    output logic                       busy,
    output logic                       xfer_done,
    output logic                       start_read,
    output logic [ADDR_WIDTH-1:0]      target_read_addr,
    output logic [BURST_LEN_WIDTH-1:0] target_read_burst_len,
    input  logic                       done_read,
    output logic                       start_write,
    output logic [ADDR_WIDTH-1:0]      target_write_addr,
    output logic [BURST_LEN_WIDTH-1:0] target_write_burst_len,
    input  logic                       done_write,
    output logic [2:0]                 dbg_state
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_CALC     = 3'd1;
    localparam logic [2:0] S_RD_START = 3'd2;
    localparam logic [2:0] S_RD_WAIT  = 3'd3;
    localparam logic [2:0] S_WR_START = 3'd4;
    localparam logic [2:0] S_WR_WAIT  = 3'd5;
    localparam logic [2:0] S_DONE     = 3'd6;

    // Wide enough for the word count and for the page room (up to 1024).
    localparam int BW = (COUNT_WIDTH > 11) ? COUNT_WIDTH : 11;

    logic [2:0]                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]      src_q, src_d;
    logic [ADDR_WIDTH-1:0]      dst_q, dst_d;
    logic [COUNT_WIDTH-1:0]     rem_q, rem_d;
    logic [BW-1:0]              beats_q, beats_d;
    logic [ADDR_WIDTH-1:0]      rd_addr_q, rd_addr_d;
    logic [ADDR_WIDTH-1:0]      wr_addr_q, wr_addr_d;
    logic [BURST_LEN_WIDTH-1:0] len_q, len_d;

    logic [BW-1:0]              rem_ext, max_ext, src_room, dst_room, beats_calc;
    logic [COUNT_WIDTH-1:0]     rem_next;
    logic [ADDR_WIDTH-1:0]      byte_step;
    logic                       unused_addr_lsbs;

    // Word addresses only: the byte-lane bits of the command are discarded.
    assign unused_addr_lsbs = ^{cmd_src_addr[1:0], cmd_dst_addr[1:0]};

    // Words left before the next 4 KB page on each side.
    assign rem_ext  = BW'(rem_q);
    assign max_ext  = BW'(MAX_BURST);
    assign src_room = BW'(11'd1024 - {1'b0, src_q[11:2]});
    assign dst_room = BW'(11'd1024 - {1'b0, dst_q[11:2]});

    // Burst size is the smallest of the four limits.
    always_comb begin
        beats_calc = rem_ext;
        if (max_ext < beats_calc)  beats_calc = max_ext;
        if (src_room < beats_calc) beats_calc = src_room;
        if (dst_room < beats_calc) beats_calc = dst_room;
    end

    assign rem_next  = rem_q - COUNT_WIDTH'(beats_q);
    assign byte_step = ADDR_WIDTH'(beats_q) << 2;

    // Next-state and datapath update for the burst sequencer.
    always_comb begin
        state_d   = state_q;
        src_d     = src_q;
        dst_d     = dst_q;
        rem_d     = rem_q;
        beats_d   = beats_q;
        rd_addr_d = rd_addr_q;
        wr_addr_d = wr_addr_q;
        len_d     = len_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    src_d   = {cmd_src_addr[ADDR_WIDTH-1:2], 2'b00};
                    dst_d   = {cmd_dst_addr[ADDR_WIDTH-1:2], 2'b00};
                    rem_d   = cmd_words;
                    state_d = (cmd_words == '0) ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                beats_d   = beats_calc;
                len_d     = BURST_LEN_WIDTH'(beats_calc - BW'(1));
                rd_addr_d = src_q;
                wr_addr_d = dst_q;
                state_d   = S_RD_START;
            end
            S_RD_START: state_d = S_RD_WAIT;
            S_RD_WAIT: begin
                if (done_read) state_d = S_WR_START;
            end
            S_WR_START: state_d = S_WR_WAIT;
            S_WR_WAIT: begin
                if (done_write) begin
                    src_d   = src_q + byte_step;
                    dst_d   = dst_q + byte_step;
                    rem_d   = rem_next;
                    state_d = (rem_next == '0) ? S_DONE : S_CALC;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset drops any in-flight command.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            src_q     <= '0;
            dst_q     <= '0;
            rem_q     <= '0;
            beats_q   <= '0;
            rd_addr_q <= '0;
            wr_addr_q <= '0;
            len_q     <= '0;
        end else begin
            state_q   <= state_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            rem_q     <= rem_d;
            beats_q   <= beats_d;
            rd_addr_q <= rd_addr_d;
            wr_addr_q <= wr_addr_d;
            len_q     <= len_d;
        end
    end

    assign cmd_ready              = (state_q == S_IDLE);
    assign busy                   = (state_q != S_IDLE);
    assign xfer_done              = (state_q == S_DONE);
    assign start_read             = (state_q == S_RD_START);
    assign start_write            = (state_q == S_WR_START);
    assign target_read_addr       = rd_addr_q;
    assign target_write_addr      = wr_addr_q;
    assign target_read_burst_len  = len_q;
    assign target_write_burst_len = len_q;
    assign dbg_state              = state_q;

endmodule

// File: tb/tb_axi_dma_burst_scheduler.sv
// Directed bench for axi_dma_burst_scheduler: a small master model answers
// each start pulse, and burst addresses/lengths are checked against a queue
// of hand-computed expected bursts {src, dst, len}.
module tb_axi_dma_burst_scheduler;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_src_addr;
    logic [31:0] cmd_dst_addr;
    logic [15:0] cmd_words;
    logic        busy;
    logic        xfer_done;
    logic        start_read;
    logic [31:0] target_read_addr;
    logic [7:0]  target_read_burst_len;
    logic        done_read;
    logic        start_write;
    logic [31:0] target_write_addr;
    logic [7:0]  target_write_burst_len;
    logic        done_write;
    logic [2:0]  dbg_state;

    logic [71:0] exp_q[$];
    int          n_vec;
    int          n_err;
    int          rd_pulses;
    int          wr_pulses;

    axi_dma_burst_scheduler #(
        .ADDR_WIDTH(32), .BURST_LEN_WIDTH(8), .MAX_BURST(16), .COUNT_WIDTH(16)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_src_addr(cmd_src_addr), .cmd_dst_addr(cmd_dst_addr), .cmd_words(cmd_words),
        .busy(busy), .xfer_done(xfer_done),
        .start_read(start_read), .target_read_addr(target_read_addr),
        .target_read_burst_len(target_read_burst_len), .done_read(done_read),
        .start_write(start_write), .target_write_addr(target_write_addr),
        .target_write_burst_len(target_write_burst_len), .done_write(done_write),
        .dbg_state(dbg_state)
    );

    // Clock and pulse counters.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (start_read)  rd_pulses++;
        if (start_write) wr_pulses++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, "_cmd_ready"}, cmd_ready, 1);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_xfer_done"}, xfer_done, 0);
        check_eq({tag, "_start_read"}, start_read, 0);
        check_eq({tag, "_start_write"}, start_write, 0);
        check_eq({tag, "_rd_addr"}, target_read_addr, 0);
        check_eq({tag, "_wr_addr"}, target_write_addr, 0);
        check_eq({tag, "_rd_len"}, target_read_burst_len, 0);
        check_eq({tag, "_wr_len"}, target_write_burst_len, 0);
        check_eq({tag, "_state"}, dbg_state, 0);
    endtask

    // Called at a negedge with the DUT idle; returns at the CALC negedge.
    task automatic send_cmd(input logic [31:0] s, input logic [31:0] d, input logic [15:0] w);
        check_eq("cmd_ready_before", cmd_ready, 1);
        cmd_src_addr = s;
        cmd_dst_addr = d;
        cmd_words    = w;
        cmd_valid    = 1'b1;
        @(negedge clk);
        cmd_valid    = 1'b0;
    endtask

    task automatic wait_start_read(output int lat);
        lat = 0;
        while (!start_read && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        if (!start_read) check_eq("rd_timeout", start_read, 1);
    endtask

    // Serves one burst from the CALC negedge to the negedge after done_write.
    task automatic do_burst(input int rd_dly, input int wr_dly, input bit stray);
        logic [71:0] e;
        int lat;
        if (exp_q.size() == 0) begin
            check_eq("exp_q_underflow", exp_q.size(), 1);
            return;
        end
        e = exp_q.pop_front();
        wait_start_read(lat);
        check_eq("rd_lat", lat, 1);
        check_eq("rd_addr", target_read_addr, e[71:40]);
        check_eq("rd_len", target_read_burst_len, e[7:0]);
        @(negedge clk);
        check_eq("rd_pulse_width", start_read, 0);
        if (stray) begin
            done_write = 1'b1;
            @(negedge clk);
            done_write = 1'b0;
            check_eq("stray_dw_state", dbg_state, 3);
        end
        repeat (rd_dly) @(negedge clk);
        check_eq("wr_not_early", start_write, 0);
        done_read = 1'b1;
        @(negedge clk);
        done_read = 1'b0;
        check_eq("wr_lat", start_write, 1);
        check_eq("wr_addr", target_write_addr, e[39:8]);
        check_eq("wr_len", target_write_burst_len, e[7:0]);
        check_eq("rd_addr_stable", target_read_addr, e[71:40]);
        @(negedge clk);
        check_eq("wr_pulse_width", start_write, 0);
        if (stray) begin
            done_read = 1'b1;
            @(negedge clk);
            done_read = 1'b0;
            check_eq("stray_dr_state", dbg_state, 5);
        end
        repeat (wr_dly) @(negedge clk);
        done_write = 1'b1;
        @(negedge clk);
        done_write = 1'b0;
    endtask

    task automatic finish_cmd(input string tag);
        check_eq({tag, "_xfer_done"}, xfer_done, 1);
        @(negedge clk);
        check_eq({tag, "_xfer_done_width"}, xfer_done, 0);
        check_eq({tag, "_ready_again"}, cmd_ready, 1);
        check_eq({tag, "_busy_clear"}, busy, 0);
    endtask

    initial begin
        int lat;
        int rp, wp;
        n_vec = 0; n_err = 0; rd_pulses = 0; wr_pulses = 0;
        rst = 1'b1; cmd_valid = 1'b0; cmd_src_addr = '0; cmd_dst_addr = '0;
        cmd_words = '0; done_read = 1'b0; done_write = 1'b0;
        repeat (3) @(negedge clk);
        check_idle("reset");
        rst = 1'b0;
        @(negedge clk);

        // Split at MAX_BURST.
        exp_q.push_back({32'h0000_1000, 32'h0000_2000, 8'd15});
        exp_q.push_back({32'h0000_1040, 32'h0000_2040, 8'd3});
        send_cmd(32'h0000_1000, 32'h0000_2000, 16'd20);
        check_eq("split_busy", busy, 1);
        check_eq("split_ready_low", cmd_ready, 0);
        check_eq("split_calc_no_start", start_read, 0);
        do_burst(0, 0, 0);
        check_eq("split_no_early_done", xfer_done, 0);
        do_burst(2, 3, 0);
        finish_cmd("split");

        // 4 KB boundary on the source, then on the destination.
        exp_q.push_back({32'h0000_1FF8, 32'h0000_3000, 8'd1});
        exp_q.push_back({32'h0000_2000, 32'h0000_3008, 8'd2});
        send_cmd(32'h0000_1FF8, 32'h0000_3000, 16'd5);
        do_burst(1, 1, 0);
        do_burst(0, 2, 0);
        finish_cmd("src4k");
        exp_q.push_back({32'h0000_3000, 32'h0000_1FF8, 8'd1});
        exp_q.push_back({32'h0000_3008, 32'h0000_2000, 8'd2});
        send_cmd(32'h0000_3000, 32'h0000_1FF9, 16'd5);
        do_burst(0, 0, 0);
        do_burst(0, 0, 0);
        finish_cmd("dst4k");

        // Zero-word command.
        rp = rd_pulses; wp = wr_pulses;
        send_cmd(32'h0000_5000, 32'h0000_6000, 16'd0);
        finish_cmd("zero");
        @(negedge clk);
        check_eq("zero_no_rd", rd_pulses, rp);
        check_eq("zero_no_wr", wr_pulses, wp);

        // Long done_read delay, stray dones, cmd_valid held while busy.
        exp_q.push_back({32'h0000_4000, 32'h0000_5000, 8'd3});
        exp_q.push_back({32'h0000_6004, 32'h0000_7000, 8'd1});
        cmd_src_addr = 32'h0000_4000; cmd_dst_addr = 32'h0000_5000; cmd_words = 16'd4;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_src_addr = 32'h0000_6004; cmd_dst_addr = 32'h0000_7000; cmd_words = 16'd2;
        check_eq("hold_ready_low", cmd_ready, 0);
        do_burst(50, 0, 1);
        check_eq("hold_done_ready_low", cmd_ready, 0);
        check_eq("hold_done_pulse", xfer_done, 1);
        @(negedge clk);
        check_eq("hold_idle_ready", cmd_ready, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
        check_eq("hold_second_taken", busy, 1);
        do_burst(0, 0, 0);
        finish_cmd("hold");

        // Reset while waiting on burst 2's read.
        exp_q.push_back({32'h0000_8000, 32'h0000_9000, 8'd15});
        send_cmd(32'h0000_8000, 32'h0000_9000, 16'd20);
        do_burst(0, 0, 0);
        wait_start_read(lat);
        check_eq("mid_rd_addr", target_read_addr, 32'h0000_8040);
        check_eq("mid_rd_len", target_read_burst_len, 3);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_idle("mid_rst");
        rst = 1'b0;
        rp = rd_pulses; wp = wr_pulses;
        repeat (4) @(negedge clk);
        check_eq("mid_no_rd_after", rd_pulses, rp);
        check_eq("mid_no_wr_after", wr_pulses, wp);
        exp_q.push_back({32'h0000_A000, 32'h0000_B000, 8'd2});
        send_cmd(32'h0000_A000, 32'h0000_B000, 16'd3);
        do_burst(0, 0, 0);
        finish_cmd("post_rst");

        // Address wrap at the top of the space.
        exp_q.push_back({32'hFFFF_FFF8, 32'h0000_0100, 8'd1});
        exp_q.push_back({32'h0000_0000, 32'h0000_0108, 8'd1});
        send_cmd(32'hFFFF_FFFB, 32'h0000_0100, 16'd4);
        do_burst(0, 0, 0);
        do_burst(0, 0, 0);
        finish_cmd("wrap");

        check_eq("exp_q_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
